xadc_temp_reader: RTL
=====================

Name: xadc_temp_reader

Overview:
- Upstream feeder for the 7-segment temperature display. Periodically reads the XADC on-chip temperature register over the DRP port and converts the 12-bit code to integer °C.
- Presents the result as temp_c[7:0], clamped to the 0-199 range the display stage can render.
- Holds the last good value between samples and flags DRP read timeouts.

Parameters:
- SAMPLE_DIV, 100000000, clk cycles between read requests (1 Hz at 100 MHz); min 8
- TIMEOUT, 255, max cycles to wait for drp_drdy after request
- TEMP_MAX, 199, upper clamp for temp_c

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous, active-high reset
- drp_den  out  1  DRP enable, one-cycle pulse per read
- drp_dwe  out  1  DRP write enable, constant 0
- drp_daddr  out  7  DRP address, constant 7'h00 (temperature)
- drp_di  out  16  DRP write data, constant 16'h0000
- drp_do  in  16  DRP read data; code in [15:4]
- drp_drdy  in  1  DRP data ready, one-cycle pulse
- temp_c  out  8  temperature in °C, integer, clamped 0..TEMP_MAX
- temp_valid  out  1  one-cycle pulse when temp_c updates
- raw_code  out  12  last captured XADC code
- drp_timeout  out  1  sticky error flag; cleared by next successful read or rst

Behaviour:
- Reset: all outputs 0, FSM = IDLE, sample counter = 0.
- Sample counter counts 0..SAMPLE_DIV-1 and wraps. A tick fires when it equals SAMPLE_DIV-1, so the first tick comes SAMPLE_DIV cycles after rst deasserts.
- A tick that fires while the FSM is not IDLE is dropped. The counter never stalls.
- FSM states:
  - IDLE: on tick go to REQ.
  - REQ: drp_den=1 for exactly this cycle; go to WAIT with wait counter = 0.
  - WAIT: if drp_drdy=1, capture drp_do[15:4] into raw_code and go to CONV. Else, if the wait counter reaches TIMEOUT-1, set drp_timeout=1 and return to IDLE (temp_c held, no temp_valid). Else increment the wait counter.
  - CONV: register prod = raw_code * 32254 (27-bit unsigned product); go to OUT.
  - OUT: compute kelvin = prod >> 18 (truncating, 0..503) and t = kelvin - 273 (signed). Then:
    - t < 0: temp_c = 0
    - t > TEMP_MAX: temp_c = TEMP_MAX
    - otherwise temp_c = t
    - Same edge: temp_valid=1 for one cycle, drp_timeout cleared. Go to IDLE.
- Latency: drdy sampled high at edge N -> temp_c/temp_valid updated at edge N+2.
- drp_drdy arriving outside WAIT is ignored.
- drdy and timeout on the same cycle: drdy wins (successful read).
- rst mid-transaction: FSM to IDLE, drp_den=0, and all outputs and flags return to their reset values. A late drdy after reset is ignored.
- drp_den is never asserted again until the current transaction completes or times out.

Optional Feature:
- Macro: XADC_TEMP_AVG_EN.
- Defined:
  - A 14-bit accumulator sums 4 consecutive successful codes.
  - CONV runs only on the 4th; it uses (sum >> 2) as the code input to the multiply.
  - temp_valid pulses once per 4 successful reads.
  - raw_code still updates every read.
  - A timeout clears the accumulator and sample count.
- Undefined: every successful read converts and updates temp_c directly. No accumulator logic is present.

Test Plan:
- SAMPLE_DIV=16. After rst, drp_den pulses first at cycle 16 with daddr=7'h00 and dwe=0. Responder returns drp_do=16'h9760 (code 2422) with drdy 3 cycles later -> temp_c=25 and temp_valid pulses 2 cycles after drdy; raw_code=12'h976.
- Clamp tests:
  - code 2219 (16'h8AB0) -> temp_c=0.
  - code 2218 (16'h8AA0) -> temp_c=0 (t=-1 clamped).
  - code 4095 (16'hFFF0) -> temp_c=199.
  - code 0 -> temp_c=0.
- Timeout: TIMEOUT=8, responder never asserts drdy -> drp_timeout=1 eight cycles after drp_den, temp_c keeps previous value, no temp_valid. Next good read (code 2422) -> drp_timeout=0, temp_c=25.
- Busy drop and stray drdy: SAMPLE_DIV=8, responder delays drdy 10 cycles -> exactly one drp_den per transaction, intervening tick dropped. A drdy pulse while IDLE causes no raw_code/temp_c change.
- Reset mid-WAIT: assert rst 2 cycles after drp_den; drdy arrives after rst deasserts -> all outputs 0, no temp_valid, next drp_den at SAMPLE_DIV cycles after reset release.
- With XADC_TEMP_AVG_EN: codes 2414, 2422, 2422, 2430 (average 2422) -> one temp_valid after the 4th read with temp_c=25, raw_code=12'h97E.

Source files
------------

// File: rtl/xadc_temp_reader.sv
// Periodic XADC on-chip temperature reader over DRP; converts the 12-bit code to integer degC.
// Optional feature macro XADC_TEMP_AVG_EN: average four successful reads before each conversion.
module xadc_temp_reader #(
    parameter int unsigned SAMPLE_DIV = 100000000,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned TEMP_MAX   = 199
) (
    input  logic        clk,
    input  logic        rst,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic [7:0]  temp_c,
    output logic        temp_valid,
    output logic [11:0] raw_code,
    output logic        drp_timeout
);

    localparam int unsigned DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned WAIT_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned CODE_W   = 12;
    localparam int unsigned PROD_W   = 27;
    localparam int unsigned K_W      = 9;
    localparam int unsigned T_W      = 8;
    localparam int unsigned SCALE    = 32254;
    localparam int unsigned KSHIFT   = 18;
    localparam int unsigned KELVIN_0 = 273;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CONV,
        S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CODE_W-1:0]   raw_q, raw_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [T_W-1:0]      temp_q, temp_d;
    logic                valid_q, valid_d;
    logic                den_q, den_d;
    logic                tout_q, tout_d;

    logic                tick_c;
    logic [CODE_W-1:0]   mult_code_c;
    logic [K_W-1:0]      kelvin_c;
    logic [K_W-1:0]      above_c;
    logic [T_W-1:0]      temp_conv_c;
    logic                unused_c;

`ifdef XADC_TEMP_AVG_EN
    localparam int unsigned ACC_W = 14;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [1:0]          avg_cnt_q, avg_cnt_d;

    assign mult_code_c = acc_q[ACC_W-1:2];
    assign unused_c    = ^{drp_do[3:0], acc_q[1:0]};
`else
    assign mult_code_c = raw_q;
    assign unused_c    = ^drp_do[3:0];
`endif

    // Free-running sample divider; never stalls, ticks on its last count.
    always_comb begin
        tick_c = (div_q == DIV_W'(SAMPLE_DIV - 1));
        div_d  = tick_c ? '0 : div_q + DIV_W'(1);
    end

    // Kelvin = prod >> 18, then offset to degC and clamp to the displayable range.
    always_comb begin
        kelvin_c = K_W'(prod_q >> KSHIFT);
        above_c  = kelvin_c - K_W'(KELVIN_0);
        if (kelvin_c < K_W'(KELVIN_0)) begin
            temp_conv_c = '0;
        end else if (above_c > K_W'(TEMP_MAX)) begin
            temp_conv_c = T_W'(TEMP_MAX);
        end else begin
            temp_conv_c = T_W'(above_c);
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        raw_d   = raw_q;
        prod_d  = prod_q;
        temp_d  = temp_q;
        valid_d = 1'b0;
        den_d   = 1'b0;
        tout_d  = tout_q;
`ifdef XADC_TEMP_AVG_EN
        acc_d     = acc_q;
        avg_cnt_d = avg_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (tick_c) begin
                    state_d = S_REQ;
                    den_d   = 1'b1;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                // drdy takes priority over an expiring wait counter
                if (drp_drdy) begin
                    raw_d = drp_do[15:4];
`ifdef XADC_TEMP_AVG_EN
                    acc_d  = acc_q + ACC_W'(drp_do[15:4]);
                    tout_d = 1'b0;
                    if (avg_cnt_q == 2'd3) begin
                        avg_cnt_d = '0;
                        state_d   = S_CONV;
                    end else begin
                        avg_cnt_d = avg_cnt_q + 2'd1;
                        state_d   = S_IDLE;
                    end
`else
                    state_d = S_CONV;
`endif
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    state_d = S_IDLE;
`ifdef XADC_TEMP_AVG_EN
                    acc_d     = '0;
                    avg_cnt_d = '0;
`endif
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_CONV: begin
                prod_d  = PROD_W'(mult_code_c) * PROD_W'(SCALE);
                state_d = S_OUT;
`ifdef XADC_TEMP_AVG_EN
                acc_d = '0;
`endif
            end
            S_OUT: begin
                temp_d  = temp_conv_c;
                valid_d = 1'b1;
                tout_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            wait_q  <= '0;
            raw_q   <= '0;
            prod_q  <= '0;
            temp_q  <= '0;
            valid_q <= 1'b0;
            den_q   <= 1'b0;
            tout_q  <= 1'b0;
`ifdef XADC_TEMP_AVG_EN
            acc_q     <= '0;
            avg_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            wait_q  <= wait_d;
            raw_q   <= raw_d;
            prod_q  <= prod_d;
            temp_q  <= temp_d;
            valid_q <= valid_d;
            den_q   <= den_d;
            tout_q  <= tout_d;
`ifdef XADC_TEMP_AVG_EN
            acc_q     <= acc_d;
            avg_cnt_q <= avg_cnt_d;
`endif
        end
    end

    assign drp_den     = den_q;
    assign drp_dwe     = 1'b0;
    assign drp_daddr   = 7'h00;
    assign drp_di      = 16'h0000;
    assign temp_c      = temp_q;
    assign temp_valid  = valid_q;
    assign raw_code    = raw_q;
    assign drp_timeout = tout_q;

endmodule
